// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: active-low strobe levels and pointer/level width helpers.
package fifo_pkg;

    localparam logic nT = 1'b0;
    localparam logic nF = 1'b1;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the level can represent DEPTH itself.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_lvl_ram.sv
// FIFO storage: one registered write port, one asynchronous read port, no reset.
module fifo_lvl_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_lvl.sv
// Level-tracking synchronous FIFO with active-low strobes and sticky error flags.
// Define FIFO_LVL_FWFT_EN for first-word-fall-through output; default is registered read.
module fifo_lvl
    import fifo_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [WIDTH-1:0]         port_in,
    input  logic                     n_wr,
    input  logic                     n_rd,
    input  logic                     n_clr,
    output logic [WIDTH-1:0]         port_out,
    output logic [lvl_w(DEPTH)-1:0]  level,
    output logic                     n_empty,
    output logic                     n_full,
    output logic                     n_aempty,
    output logic                     n_afull,
    output logic                     n_ovf,
    output logic                     n_udf
);

    localparam int PW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(AF_LEVEL);
    localparam logic [LW-1:0] AE_LVL   = LW'(AE_LEVEL);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_lvl: DEPTH must be a power of two >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_lvl: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_lvl: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic [PW-1:0]    rp, wp;
    logic [WIDTH-1:0] rd_data, out_q;
    logic             ovf_q, udf_q;
    logic             wr_req, rd_req, clr_req, is_empty, is_full, do_wr, do_rd;

    assign wr_req   = (n_wr == nT);
    assign rd_req   = (n_rd == nT);
    assign clr_req  = (n_clr == nT);
    assign is_empty = (level == '0);
    assign is_full  = (level == FULL_LVL);
    // A read on a full FIFO frees the slot the concurrent write lands in.
    assign do_wr    = wr_req && (!is_full || rd_req);
    assign do_rd    = rd_req && !is_empty;

    fifo_lvl_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(PW)) u_ram (
        .clk   (clk),
        .we    (do_wr && !clr_req),
        .waddr (wp),
        .wdata (port_in),
        .raddr (rp),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rp    <= '0;
            wp    <= '0;
            level <= '0;
            out_q <= '0;
            ovf_q <= nF;
            udf_q <= nF;
        end else if (clr_req) begin
            rp    <= '0;
            wp    <= '0;
            level <= '0;
            ovf_q <= nF;
            udf_q <= nF;
`ifdef FIFO_LVL_FWFT_EN
            // Freeze the word currently on port_out so a flush does not change it.
            if (!is_empty) out_q <= rd_data;
`endif
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) begin
                rp    <= rp + 1'b1;
                out_q <= rd_data;
            end
            if (do_wr && !do_rd)      level <= level + 1'b1;
            else if (do_rd && !do_wr) level <= level - 1'b1;
            if (wr_req && !rd_req && is_full)  ovf_q <= nT;
            if (rd_req && !wr_req && is_empty) udf_q <= nT;
        end
    end

`ifdef FIFO_LVL_FWFT_EN
    // Head word falls through; when empty, keep showing the last word popped.
    assign port_out = is_empty ? out_q : rd_data;
`else
    assign port_out = out_q;
`endif

    assign n_empty  = is_empty ? nT : nF;
    assign n_full   = is_full ? nT : nF;
    assign n_aempty = (level <= AE_LVL) ? nT : nF;
    assign n_afull  = (level >= AF_LVL) ? nT : nF;
    assign n_ovf    = ovf_q;
    assign n_udf    = udf_q;

endmodule

// File: tb/tb_fifo_lvl.sv
// Directed self-checking bench for fifo_lvl (DEPTH=16, WIDTH=8, AF=14, AE=2), either output mode.
module tb_fifo_lvl;

    logic       clk = 1'b0;
    logic       n_rst, n_wr, n_rd, n_clr;
    logic [7:0] port_in, port_out;
    logic [4:0] level;
    logic       n_empty, n_full, n_aempty, n_afull, n_ovf, n_udf;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    fifo_lvl #(.DEPTH(16), .WIDTH(8), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
        .clk(clk), .n_rst(n_rst), .port_in(port_in), .n_wr(n_wr), .n_rd(n_rd),
        .n_clr(n_clr), .port_out(port_out), .level(level), .n_empty(n_empty),
        .n_full(n_full), .n_aempty(n_aempty), .n_afull(n_afull),
        .n_ovf(n_ovf), .n_udf(n_udf)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        n_wr = ~w; n_rd = ~r; port_in = d;
        @(posedge clk); @(negedge clk);
        n_wr = 1'b1; n_rd = 1'b1;
    endtask

    // Read (optionally with a concurrent write) and return the popped word.
    task automatic xfer(input logic w, input logic [7:0] d, output logic [7:0] v);
`ifdef FIFO_LVL_FWFT_EN
        v = port_out;
        step(w, 1'b1, d);
`else
        step(w, 1'b1, d);
        v = port_out;
`endif
    endtask

    task automatic clr_pulse();
        n_clr = 1'b0;
        @(posedge clk); @(negedge clk);
        n_clr = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; n_wr = 1'b1; n_rd = 1'b1; n_clr = 1'b1; port_in = '0;
        repeat (2) @(negedge clk);
        checks++; if (level !== 5'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", level); end
        checks++; if (port_out !== 8'h00) begin failures++; $display("FAIL rst_port_out got=%h exp=00", port_out); end
        checks++; if ({n_empty, n_full, n_aempty, n_afull, n_ovf, n_udf} !== 6'b010111) begin
            failures++; $display("FAIL rst_flags got=%b exp=010111", {n_empty, n_full, n_aempty, n_afull, n_ovf, n_udf}); end
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_order();
        logic [7:0] v;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
        checks++; if (level !== 5'd16) begin failures++; $display("FAIL order_full_level got=%0d exp=16", level); end
        checks++; if ({n_empty, n_full, n_aempty, n_afull} !== 4'b1010) begin
            failures++; $display("FAIL order_full_flags got=%b exp=1010", {n_empty, n_full, n_aempty, n_afull}); end
        for (int i = 0; i < 16; i++) begin
            xfer(1'b0, 8'h00, v);
            checks++; if (v !== 8'(i)) begin failures++; $display("FAIL order_data[%0d] got=%h exp=%h", i, v, 8'(i)); end
        end
        checks++; if (level !== 5'd0 || n_empty !== 1'b0) begin
            failures++; $display("FAIL order_empty got level=%0d n_empty=%b exp level=0 n_empty=0", level, n_empty); end
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
        step(1'b1, 1'b0, 8'hAA);
        checks++; if (level !== 5'd16 || n_ovf !== 1'b0) begin
            failures++; $display("FAIL ovf_flag got level=%0d n_ovf=%b exp level=16 n_ovf=0", level, n_ovf); end
        for (int i = 0; i < 16; i++) begin
            xfer(1'b0, 8'h00, v);
            checks++; if (v !== 8'(8'h10 + i)) begin failures++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, v, 8'(8'h10 + i)); end
        end
        checks++; if (n_ovf !== 1'b0) begin failures++; $display("FAIL ovf_sticky got=%b exp=0", n_ovf); end
        clr_pulse();
        checks++; if (n_ovf !== 1'b1) begin failures++; $display("FAIL ovf_clr got=%b exp=1", n_ovf); end
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b1, 8'h00);
        checks++; if (n_udf !== 1'b0 || level !== 5'd0) begin
            failures++; $display("FAIL udf_flag got n_udf=%b level=%0d exp n_udf=0 level=0", n_udf, level); end
        checks++; if (port_out !== 8'h1F) begin failures++; $display("FAIL udf_hold got=%h exp=1f", port_out); end
        clr_pulse();
        checks++; if (n_udf !== 1'b1) begin failures++; $display("FAIL udf_clr got=%b exp=1", n_udf); end
        checks++; if (port_out !== 8'h1F) begin failures++; $display("FAIL clr_port_out got=%h exp=1f", port_out); end
    endtask

    task automatic test_simul();
        logic [7:0] v, exp_out;
        step(1'b1, 1'b1, 8'h55);
        checks++; if (level !== 5'd1 || n_udf !== 1'b1) begin
            failures++; $display("FAIL rw_empty got level=%0d n_udf=%b exp level=1 n_udf=1", level, n_udf); end
`ifdef FIFO_LVL_FWFT_EN
        exp_out = 8'h55;
`else
        exp_out = 8'h1F;
`endif
        checks++; if (port_out !== exp_out) begin failures++; $display("FAIL rw_empty_out got=%h exp=%h", port_out, exp_out); end
        for (int i = 1; i < 16; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
        xfer(1'b1, 8'h77, v);
        checks++; if (v !== 8'h55) begin failures++; $display("FAIL rw_full_data got=%h exp=55", v); end
        checks++; if (level !== 5'd16 || n_ovf !== 1'b1) begin
            failures++; $display("FAIL rw_full got level=%0d n_ovf=%b exp level=16 n_ovf=1", level, n_ovf); end
        for (int i = 1; i < 17; i++) begin
            xfer(1'b0, 8'h00, v);
            exp_out = (i == 16) ? 8'h77 : 8'(8'h60 + i);
            checks++; if (v !== exp_out) begin failures++; $display("FAIL rw_drain[%0d] got=%h exp=%h", i, v, exp_out); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] v, e;
        logic [7:0] q[$];
        logic       exp_f;
        clr_pulse();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'(8'hA0 + i)); q.push_back(8'(8'hA0 + i));
            exp_f = (i + 1 <= 2) ? 1'b0 : 1'b1;
            checks++; if (n_aempty !== exp_f) begin failures++; $display("FAIL aempty_fill lvl=%0d got=%b exp=%b", i + 1, n_aempty, exp_f); end
        end
        for (int i = 0; i < 20; i++) begin
            xfer(1'b1, 8'(8'hC0 + i), v); e = q.pop_front(); q.push_back(8'(8'hC0 + i));
            checks++; if (v !== e || level !== 5'd8) begin
                failures++; $display("FAIL wrap[%0d] got data=%h level=%0d exp data=%h level=8", i, v, level, e); end
        end
        for (int l = 9; l <= 16; l++) begin
            step(1'b1, 1'b0, 8'(8'hE0 + l)); q.push_back(8'(8'hE0 + l));
            exp_f = (l >= 14) ? 1'b0 : 1'b1;
            checks++; if (n_afull !== exp_f) begin failures++; $display("FAIL afull lvl=%0d got=%b exp=%b", l, n_afull, exp_f); end
        end
        for (int l = 15; l >= 0; l--) begin
            xfer(1'b0, 8'h00, v); e = q.pop_front();
            exp_f = (l <= 2) ? 1'b0 : 1'b1;
            checks++; if (v !== e || n_aempty !== exp_f) begin
                failures++; $display("FAIL drain lvl=%0d got data=%h n_aempty=%b exp data=%h n_aempty=%b", l, v, n_aempty, e, exp_f); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        clr_pulse();
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
        xfer(1'b0, 8'h00, v);
        checks++; if (v !== 8'h31 || level !== 5'd5) begin
            failures++; $display("FAIL mid_pre got data=%h level=%0d exp data=31 level=5", v, level); end
        n_rst = 1'b0;
        #1;
        checks++; if (level !== 5'd0 || port_out !== 8'h00) begin
            failures++; $display("FAIL mid_rst got level=%0d port_out=%h exp level=0 port_out=00", level, port_out); end
        checks++; if ({n_empty, n_full, n_aempty, n_afull, n_ovf, n_udf} !== 6'b010111) begin
            failures++; $display("FAIL mid_rst_flags got=%b exp=010111", {n_empty, n_full, n_aempty, n_afull, n_ovf, n_udf}); end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        step(1'b1, 1'b0, 8'h99);
        xfer(1'b0, 8'h00, v);
        checks++; if (v !== 8'h99 || level !== 5'd0) begin
            failures++; $display("FAIL mid_post got data=%h level=%0d exp data=99 level=0", v, level); end
    endtask

    initial begin
        test_reset();
        test_order();
        test_overflow();
        test_underflow();
        test_simul();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
